// File: rtl/mips_program_loader.sv
// Streams instruction words into instruction memory, screens each opcode,
// and holds the MIPS core in reset until a program ends cleanly in HALT.
module mips_program_loader #(
   parameter int MIPS_DATA_WIDTH        = 32,
   parameter int MIPS_MEMORY_ADDR_WIDTH = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [MIPS_DATA_WIDTH-1:0]        in_data,
   output logic                              mem_we,
   output logic [MIPS_MEMORY_ADDR_WIDTH-1:0] mem_addr,
   output logic [MIPS_DATA_WIDTH-1:0]        mem_wdata,
   output logic                              core_rst_n,
   output logic                              done,
   output logic                              error,
   output logic [MIPS_MEMORY_ADDR_WIDTH:0]   word_count
);

   localparam int AW = MIPS_MEMORY_ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE,
      ERROR
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] addr_q;
   logic          we_q;
   logic          accept;
   logic          legal;
   logic          halt;
   logic          last;

   function automatic logic is_legal(input logic [5:0] op,
                                     input logic [5:0] fn);
      logic ok;
      ok = 1'b0;
      case (op)
         6'h00: begin
            case (fn)
               6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22,
               6'h23, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h2b,
               6'h3f:   ok = 1'b1;
               default: ok = 1'b0;
            endcase
         end
         6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
         6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f, 6'h23,
         6'h24, 6'h25, 6'h28, 6'h29, 6'h2b, 6'h30,
         6'h38:   ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   assign accept = (state == LOAD) && in_valid;
   assign legal  = is_legal(in_data[31:26], in_data[5:0]);
   assign halt   = (in_data[31:26] == 6'h00) && (in_data[5:0] == 6'h3f);
   assign last   = &addr_q;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, DONE, ERROR: begin
            if (start)
               state_nxt = LOAD;
         end
         LOAD: begin
            if (accept) begin
               if (!legal || (!halt && last))
                  state_nxt = ERROR;
               else if (halt)
                  state_nxt = DONE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_q       <= 1'b0;
         addr_q     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         word_count <= '0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         we_q  <= 1'b0;
         done  <= (state_nxt == DONE);
         error <= (state_nxt == ERROR);
         if ((state != LOAD) && start) begin
            addr_q     <= '0;
            word_count <= '0;
         end
         if (accept && legal) begin
            we_q       <= 1'b1;
            mem_addr   <= addr_q;
            mem_wdata  <= in_data;
            addr_q     <= addr_q + 1'b1;
            word_count <= word_count + 1'b1;
         end
      end
   end

   // A reset arriving in the write cycle must kill that write at once.
   assign mem_we     = we_q & rst_n;
   assign in_ready   = (state == LOAD);
   assign core_rst_n = (state == DONE);

endmodule

// File: tb/tb_mips_program_loader.sv
// Randomized bench for mips_program_loader, scored against a
// list-based model of which words land in memory and how the load ends.
module tb_mips_program_loader;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam logic [5:0] OPS [20] = '{
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c,
      6'h0d, 6'h0f, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b, 6'h30, 6'h38};
   localparam logic [5:0] FNS [12] = '{
      6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22,
      6'h23, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h2b};

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          core_rst_n;
   logic          done;
   logic          error;
   logic [AW:0]   word_count;

   int checks = 0;
   int errors = 0;
   logic [39:0] obs_q [$];
   logic [39:0] exp_q [$];

   mips_program_loader #(
      .MIPS_DATA_WIDTH(DW),
      .MIPS_MEMORY_ADDR_WIDTH(AW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .core_rst_n(core_rst_n),
      .done(done),
      .error(error),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (mem_we === 1'b1)
         obs_q.push_back({mem_addr, mem_wdata});

   function automatic bit m_legal(input logic [31:0] w);
      logic [5:0] op;
      logic [5:0] fn;
      op = w[31:26];
      fn = w[5:0];
      if (op == 6'h00) begin
         foreach (FNS[i])
            if (FNS[i] == fn)
               return 1'b1;
         return fn == 6'h3f;
      end
      foreach (OPS[i])
         if (OPS[i] == op)
            return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_halt(input logic [31:0] w);
      return (w[31:26] == 6'h00) && (w[5:0] == 6'h3f);
   endfunction

   function automatic logic [31:0] rnd_legal();
      logic [31:0] w;
      w = $urandom;
      w[31:26] = OPS[$urandom_range(0, 19)];
      if (w[31:26] == 6'h00)
         w[5:0] = FNS[$urandom_range(0, 11)];
      return w;
   endfunction

   function automatic logic [31:0] rnd_illegal();
      logic [31:0] w;
      w = $urandom;
      while (m_legal(w))
         w = $urandom;
      return w;
   endfunction

   // status: 0 still loading, 1 done, 2 error
   function automatic void model(input logic [31:0] prog [$],
                                 output int status, output int wc,
                                 output int used);
      status = 0;
      wc = 0;
      used = 0;
      exp_q.delete();
      foreach (prog[i]) begin
         if (status != 0)
            break;
         used++;
         if (!m_legal(prog[i])) begin
            status = 2;
         end else begin
            exp_q.push_back({8'(wc), prog[i]});
            wc++;
            if (m_halt(prog[i]))
               status = 1;
            else if (wc == 256)
               status = 2;
         end
      end
   endfunction

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      obs_q.delete();
      start = 1'b1;
      sync();
      start = 1'b0;
   endtask

   task automatic push(input logic [31:0] w, output bit ok);
      in_valid = 1'b1;
      in_data  = w;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      sync();
      in_valid = 1'b0;
   endtask

   task automatic run(input logic [31:0] prog [$], input int gap,
                      input int start_at, output int accepted);
      bit ok;
      accepted = 0;
      foreach (prog[i]) begin
         push(prog[i], ok);
         if (!ok)
            break;
         accepted++;
         if (gap > 0) begin
            if (i == start_at)
               start = 1'b1;
            repeat (gap) sync();
            start = 1'b0;
         end
      end
      repeat (3) sync();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) sync();
      @(negedge clk);
      checks++;
      if ({in_ready, mem_we, core_rst_n, done, error} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 00000",
                  {in_ready, mem_we, core_rst_n, done, error});
      end
      checks++;
      if (mem_addr !== '0 || mem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_mem got %h/%h want 0/0", mem_addr, mem_wdata);
      end
      checks++;
      if (word_count !== '0) begin
         errors++;
         $display("FAIL reset_wc got %0d want 0", word_count);
      end
      sync();
      rst_n = 1'b1;
      sync();
   endtask

   task automatic test_normal();
      logic [31:0] prog [$];
      int acc;
      prog = '{32'h20080005, 32'h01095020, 32'h0000003f};
      exp_q = '{{8'd0, 32'h20080005}, {8'd1, 32'h01095020},
                {8'd2, 32'h0000003f}};
      do_start();
      run(prog, 0, -1, acc);
      checks++;
      if (obs_q.size() != 3) begin
         errors++;
         $display("FAIL normal_nwr got %0d want 3", obs_q.size());
      end
      foreach (exp_q[i]) begin
         if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL normal_wr%0d got %h want %h", i, obs_q[i],
                        exp_q[i]);
            end
         end
      end
      @(negedge clk);
      checks++;
      if ({done, error, core_rst_n, in_ready} !== 4'b1010
          || word_count !== 9'd3) begin
         errors++;
         $display("FAIL normal_end got d%b e%b c%b r%b wc%0d want 1 0 1 0 3",
                  done, error, core_rst_n, in_ready, word_count);
      end
      sync();
   endtask

   task automatic test_reload();
      logic [31:0] prog [$];
      int st, wc, used, acc;
      do_start();
      @(negedge clk);
      checks++;
      if ({done, core_rst_n, error, in_ready} !== 4'b0001
          || word_count !== '0) begin
         errors++;
         $display("FAIL reload_clr got d%b c%b e%b r%b wc%0d want 0 0 0 1 0",
                  done, core_rst_n, error, in_ready, word_count);
      end
      sync();
      for (int i = 0; i < 5; i++)
         prog.push_back(rnd_legal());
      prog.push_back(32'h0000003f);
      model(prog, st, wc, used);
      run(prog, 0, -1, acc);
      checks++;
      if (obs_q.size() != exp_q.size() || obs_q[0] !== exp_q[0]) begin
         errors++;
         $display("FAIL reload_wr got n%0d first %h want n%0d first %h",
                  obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 40'hx,
                  exp_q.size(), exp_q[0]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || word_count !== 9'(wc)) begin
         errors++;
         $display("FAIL reload_end got d%b wc%0d want 1 %0d", done,
                  word_count, wc);
      end
      sync();
   endtask

   task automatic test_illegal();
      logic [31:0] prog [$];
      int acc;
      prog = '{32'h20080005, 32'hfc000000};
      do_start();
      run(prog, 0, -1, acc);
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== {8'd0, 32'h20080005}) begin
         errors++;
         $display("FAIL illegal_wr got n%0d want 1 write at 0",
                  obs_q.size());
      end
      @(negedge clk);
      checks++;
      if ({error, done, core_rst_n, in_ready} !== 4'b1000
          || word_count !== 9'd1) begin
         errors++;
         $display("FAIL illegal_end got e%b d%b c%b r%b wc%0d want 1 0 0 0 1",
                  error, done, core_rst_n, in_ready, word_count);
      end
      sync();
   endtask

   task automatic test_random(input int gap, input string nm);
      logic [31:0] prog [$];
      int st, wc, used, acc, n;
      for (int t = 0; t < 4; t++) begin
         prog.delete();
         n = $urandom_range(1, 24);
         for (int i = 0; i < n; i++)
            prog.push_back(rnd_legal());
         prog.push_back(32'h0000003f);
         if ($urandom_range(0, 1) == 1)
            prog[$urandom_range(0, n)] = rnd_illegal();
         model(prog, st, wc, used);
         do_start();
         run(prog, gap, gap > 0 ? n / 2 : -1, acc);
         checks++;
         if (acc != used || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_cnt got acc%0d wr%0d want acc%0d wr%0d", nm,
                     acc, obs_q.size(), used, exp_q.size());
         end
         foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
               checks++;
               if (obs_q[i] !== exp_q[i]) begin
                  errors++;
                  $display("FAIL %s_wr%0d got %h want %h", nm, i, obs_q[i],
                           exp_q[i]);
               end
            end
         end
         @(negedge clk);
         checks++;
         if (done !== (st == 1) || error !== (st == 2)
             || core_rst_n !== (st == 1) || word_count !== 9'(wc)) begin
            errors++;
            $display("FAIL %s_end got d%b e%b c%b wc%0d want st%0d wc%0d",
                     nm, done, error, core_rst_n, word_count, st, wc);
         end
         sync();
      end
   endtask

   task automatic test_overflow();
      logic [31:0] prog [$];
      int st, wc, used, acc;
      logic [31:0] w;
      for (int i = 0; i < 257; i++) begin
         w = rnd_legal();
         while (m_halt(w))
            w = rnd_legal();
         prog.push_back(w);
      end
      model(prog, st, wc, used);
      do_start();
      run(prog, 0, -1, acc);
      checks++;
      if (acc != 256 || obs_q.size() != 256) begin
         errors++;
         $display("FAIL ovf_cnt got acc%0d wr%0d want 256 256", acc,
                  obs_q.size());
      end
      foreach (exp_q[i]) begin
         if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL ovf_wr%0d got %h want %h", i, obs_q[i],
                        exp_q[i]);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (error !== 1'b1 || done !== 1'b0 || word_count !== 9'd256) begin
         errors++;
         $display("FAIL ovf_end got e%b d%b wc%0d want 1 0 256", error, done,
                  word_count);
      end
      sync();
   endtask

   task automatic test_reset_mid();
      logic [31:0] w [3];
      bit ok;
      for (int i = 0; i < 3; i++)
         w[i] = rnd_legal();
      w[2][31:26] = 6'h08;
      do_start();
      for (int i = 0; i < 3; i++)
         push(w[i], ok);
      rst_n = 1'b0;
      sync();
      @(negedge clk);
      checks++;
      if (obs_q.size() != 2 || obs_q[0] !== {8'd0, w[0]}
          || obs_q[1] !== {8'd1, w[1]}) begin
         errors++;
         $display("FAIL rstmid_wr got n%0d want 2 writes", obs_q.size());
      end
      checks++;
      if ({in_ready, mem_we, core_rst_n, done, error} !== 5'b0
          || mem_addr !== '0 || mem_wdata !== '0 || word_count !== '0) begin
         errors++;
         $display("FAIL rstmid_out got %b a%h d%h wc%0d want zeros",
                  {in_ready, mem_we, core_rst_n, done, error}, mem_addr,
                  mem_wdata, word_count);
      end
      sync();
      rst_n = 1'b1;
      sync();
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      sync();
      test_reset();
      test_normal();
      test_reload();
      test_illegal();
      test_random(0, "rand");
      test_random(1, "throttle");
      test_overflow();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_program_loader.md
MIPS_PROGRAM_LOADER -- requirements
Module: mips_program_loader

Interface
REQ-001 The block SHALL have parameter MIPS_DATA_WIDTH, default 32: width of the instruction word.
REQ-002 The block SHALL have parameter MIPS_MEMORY_ADDR_WIDTH, default 8: word-address width; depth = 2**MIPS_MEMORY_ADDR_WIDTH.
REQ-003 The block SHALL have port clk, input, 1: the single clock, all logic on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1: single-cycle request to begin a load.
REQ-006 The block SHALL have port in_valid, input, 1: in_data holds a valid instruction word.
REQ-007 The block SHALL have port in_ready, output, 1: the loader accepts a word this cycle.
REQ-008 The block SHALL have port in_data, input, MIPS_DATA_WIDTH: the instruction word to load.
REQ-009 The block SHALL have port mem_we, output, 1: instruction-memory write strobe.
REQ-010 The block SHALL have port mem_addr, output, MIPS_MEMORY_ADDR_WIDTH: instruction-memory word address.
REQ-011 The block SHALL have port mem_wdata, output, MIPS_DATA_WIDTH: instruction-memory write data.
REQ-012 The block SHALL have port core_rst_n, output, 1: active-low reset to the MIPS core, released only after a good load.
REQ-013 The block SHALL have port done, output, 1: a program loaded and ended in HALT.
REQ-014 The block SHALL have port error, output, 1: the load was aborted.
REQ-015 The block SHALL have port word_count, output, MIPS_MEMORY_ADDR_WIDTH+1: number of words written in the current load.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, DONE and ERROR.
REQ-017 in_ready SHALL be 1 only in LOAD; a word is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-018 From IDLE, DONE or ERROR, start=1 SHALL enter LOAD next cycle and clear the address counter, word_count, done and error; core_rst_n SHALL be 0 from that cycle.
REQ-019 start SHALL be ignored in LOAD.
REQ-020 An accepted legal word SHALL produce mem_we=1, mem_addr=counter and mem_wdata=word exactly one cycle after acceptance; the counter and word_count SHALL increment together with that write; otherwise mem_we=0.
REQ-021 A word SHALL be legal when its op field (bits 31:26) is one of 0x00,02,03,04,05,08,09,0A,0B,0C,0D,0F,23,24,25,28,29,2B,30,38, and, when op=0x00, its funct field (bits 5:0) is one of 0x00,02,08,20,21,22,23,24,25,27,2A,2B or the HALT funct 0x3F.
REQ-022 A HALT word SHALL be op=0x00 with funct=0x3F; after the HALT is written, the FSM SHALL enter DONE.
REQ-023 An illegal word SHALL NOT be written; the FSM SHALL enter ERROR the cycle after it is accepted.
REQ-024 If a non-HALT legal word is written to the last address (all ones), the FSM SHALL enter ERROR after that write, with no wrap-around. A HALT at the last address SHALL enter DONE.
REQ-025 In DONE, done SHALL be 1 and core_rst_n SHALL be 1. In ERROR, error SHALL be 1 and core_rst_n SHALL be 0. Both states SHALL hold until start or reset.
REQ-026 In_ready SHALL drop to 0 on the cycle after a HALT or illegal word is accepted, so no further word is accepted.
REQ-027 word_count, mem_addr, done and error SHALL be registered outputs.

Reset
REQ-028 On rst_n=0 at a clock edge, the block SHALL enter IDLE with in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, done=0, error=0 and word_count=0.
REQ-029 A reset during LOAD SHALL abort the load immediately; a pending write scheduled for the next cycle SHALL be suppressed.

Verification
REQ-030 Scenario, normal load: start, then words 0x20080005 (addi), 0x01095020 (add), 0x0000003F (HALT) back-to-back. The bench SHALL check writes at addresses 0,1,2 with the same data, then done=1, core_rst_n=1 and word_count=3.
REQ-031 Scenario, illegal opcode: start, then 0x20080005 and 0xFC000000. The bench SHALL check only address 0 is written, error=1, core_rst_n=0, word_count=1 and in_ready=0.
REQ-032 Scenario, overflow: 256 legal non-HALT words. The bench SHALL check addresses 0..255 are written, error=1, word_count=256 and no write to address 0 again.
REQ-033 Scenario, throttled source: in_valid toggled every other cycle, with start pulsed mid-LOAD. The bench SHALL check no duplicated or dropped writes and that start is ignored.
REQ-034 Scenario, reset mid-load: rst_n=0 on the cycle after acceptance of word 2. The bench SHALL check no write for word 2 and all outputs at reset values.
REQ-035 Scenario, reload from DONE: start pulsed in DONE. The bench SHALL check done=0, core_rst_n=0 the next cycle and writes restarting at address 0.
